multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS32 core. It replaces single-cycle decode with a state machine that walks each instruction through fetch, decode, execute, memory and write-back, and drives the shared datapath's enables and mux selects. It owns the single-port memory handshake and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `opCode`  in  6  IR[31:26] from the datapath. Valid from DECODE onward.
- `alu_zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  the request is a write.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `ir_we`  out  1  load the instruction register.
- `pc_we`  out  1  load the PC.
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- `reg_we`  out  1  register-file write.
- `outReg`  out  1  destination register: 0 = rt, 1 = rd.
- `i2`  out  1  ALU operand B: 0 = register, 1 = immediate.
- `regI`  out  1  write-back source: 0 = ALU, 1 = memory data.
- `alu_op`  out  2  ALU mode: 00 = ADD, 01 = SUB, 10 = use funct field, 11 = use opcode (immediate ops).
- `illegal`  out  1  sticky trap flag.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- IDLE: all outputs are 0. The next state is FETCH unconditionally.
- FETCH: `mem_req`=1, `iord`=0, `alu_op`=ADD.
  - If `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=00, and the next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: latch `opCode` into `op_q`. All later states use `op_q`. Next state:
  - 0, 8, 10, 12, 13, 14, 35, 43 → EXEC
  - 4 → BRANCH
  - 2 → JUMP
  - any other opcode → TRAP
- EXEC: `i2`=0 for opcode 0, else 1. `alu_op` is 10 for opcode 0, 11 for 10/12/13/14, and 00 for 8/35/43. Next state:
  - 35 → MEM_RD
  - 43 → MEM_WR
  - everything else → WB_ALU
- MEM_RD and MEM_WR: `mem_req`=1, `iord`=1; `mem_we`=1 in MEM_WR only.
  - The FSM holds the state until `mem_ready`.
  - MEM_RD then goes to WB_MEM. MEM_WR then retires and goes to FETCH.
- WB_ALU: `reg_we`=1, `regI`=0, `outReg`=1 for opcode 0 and 0 for immediate ops. The instruction retires.
- WB_MEM: `reg_we`=1, `regI`=1, `outReg`=0. The instruction retires.
- BRANCH: `i2`=0, `alu_op`=SUB, `pc_src`=01, `pc_we`=`alu_zero`. The instruction retires.
- JUMP: `pc_we`=1, `pc_src`=10. The instruction retires.
- TRAP: all outputs 0 except `illegal`=1. The FSM stays in TRAP until reset.
- Retire: `instret` increments by 1 on the edge that leaves the retiring state, and wraps modulo 2^CNT_W. Entering TRAP does not count.
- Output timing: all outputs are Moore (decoded from state and `op_q`), except `ir_we`, `pc_we` and `mem_req`'s release, which depend combinationally on `mem_ready` and `alu_zero`.

## Timing
- Reset: with `rst_n`=0 at an edge, the state becomes IDLE, `op_q`=0, `instret`=0 and `illegal`=0. All outputs are 0 from that edge.
- Reset wins over any in-flight transaction. A held `mem_req` drops on the reset edge.
- Latency with `mem_ready` tied high (counted from entering FETCH):
  - ALU ops: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each cycle of `mem_ready`=0 in a memory state adds one cycle.
- `mem_req` is never deasserted before `mem_ready`. `mem_we` and `iord` are stable for the whole request.
- `opCode` changing after DECODE has no effect.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_SLTI=10, OP_ANDI=12, OP_ORI=13, OP_XORI=14, OP_LW=35, OP_SW=43)
  - the state enum
  - the `alu_op` and `pc_src` encodings
- Sub-module `opcode_class`: combinational decode of `op_q` into is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_illegal. It is shared by the next-state and output logic.

## Test plan
- Reset, then `opCode`=0 with `mem_ready`=1: observe FETCH, DECODE, EXEC (`alu_op`=10, `i2`=0), WB_ALU (`reg_we`=1, `outReg`=1). `instret` becomes 1 after cycle 4.
- lw (35) with `mem_ready` low for 3 cycles in MEM_RD: `mem_req`=1, `iord`=1 and `mem_we`=0 are held for 4 cycles. Then WB_MEM has `regI`=1, `outReg`=0. Total 8 cycles.
- beq (4) with `alu_zero`=1 and then with `alu_zero`=0: `pc_we` is 1 and 0 respectively in BRANCH, with `pc_src`=01. Both take 3 cycles and both retire.
- sw (43), then j (2): MEM_WR shows `mem_we`=1 and `reg_we` stays 0. JUMP shows `pc_we`=1, `pc_src`=10. `instret` increments by 2.
- Opcode 63: DECODE goes to TRAP, `illegal`=1 and all other outputs stay 0 for 10 cycles. `instret` is unchanged. Reset clears `illegal`.
- Assert `rst_n`=0 mid MEM_RD with `mem_req`=1: next edge gives IDLE, `mem_req`=0, `instret`=0. FETCH follows one cycle after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcode constants, sequencer state and datapath control encodings.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned PC_SRC_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_J     = 6'd2;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM_RD = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_WB_ALU = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_TRAP   = 4'd10
  } state_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier shared by the sequencer's next-state and output decode.
module opcode_class
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            is_rtype,
  output logic            is_imm,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_illegal
);

  always_comb begin
    is_rtype   = 1'b0;
    is_imm     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_RTYPE: is_rtype  = 1'b1;
      OP_ADDI,
      OP_SLTI,
      OP_ANDI,
      OP_ORI,
      OP_XORI:  is_imm    = 1'b1;
      OP_LW:    is_load   = 1'b1;
      OP_SW:    is_store  = 1'b1;
      OP_BEQ:   is_branch = 1'b1;
      OP_J:     is_jump   = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 sequencer: walks each instruction through fetch/decode/execute/memory/write-back,
// owns the single-port memory handshake and counts retired instructions.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opCode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_we,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                reg_we,
  output logic                outReg,
  output logic                i2,
  output logic                regI,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic [CNT_W-1:0]    instret
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             retire_c;

  logic is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_illegal;

  // Classify the live opcode in DECODE and the latched one everywhere after it.
  always_comb begin
    op_d = op_q;
    if (state_q == ST_DECODE) op_d = opCode;
  end

  opcode_class u_opcode_class (
    .op         (op_d),
    .is_rtype   (is_rtype),
    .is_imm     (is_imm),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and control decode; outputs follow state, with handshake-dependent strobes.
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SEQ;
    reg_we   = 1'b0;
    outReg   = 1'b0;
    i2       = 1'b0;
    regI     = 1'b0;
    alu_op   = ALU_ADD;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_illegal)     state_d = ST_TRAP;
        else if (is_branch) state_d = ST_BRANCH;
        else if (is_jump)   state_d = ST_JUMP;
        else                state_d = ST_EXEC;
      end

      ST_EXEC: begin
        i2 = !is_rtype;
        if (is_rtype)                       alu_op = ALU_FUNCT;
        else if (is_imm && op_q != OP_ADDI) alu_op = ALU_IMM;
        if (is_load)       state_d = ST_MEM_RD;
        else if (is_store) state_d = ST_MEM_WR;
        else               state_d = ST_WB_ALU;
      end

      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = ST_WB_MEM;
      end

      ST_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end
      end

      ST_WB_ALU: begin
        reg_we   = 1'b1;
        outReg   = is_rtype;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_WB_MEM: begin
        reg_we   = 1'b1;
        regI     = 1'b1;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_op   = ALU_SUB;
        pc_src   = PC_BRANCH;
        pc_we    = alu_zero;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_JUMP: begin
        pc_we    = 1'b1;
        pc_src   = PC_JUMP;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_IDLE;
    endcase
  end

  // Counter wraps naturally; the trap flag is sticky until reset.
  always_comb begin
    instret_d = instret_q;
    if (retire_c) instret_d = instret_q + CNT_W'(1);
    illegal_d = illegal_q | (state_d == ST_TRAP);
  end

  assign instret = instret_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level phase model.
module tb_multicycle_control;
  import mips_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opCode;
  logic          alu_zero;
  logic          mem_ready;
  logic          mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]    pc_src;
  logic          reg_we, outReg, i2, regI;
  logic [1:0]    alu_op;
  logic          illegal;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opCode    (opCode),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .outReg    (outReg),
    .i2        (i2),
    .regI      (regI),
    .alu_op    (alu_op),
    .illegal   (illegal),
    .instret   (instret)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int retired  = 0;

  logic [5:0] legal_ops [10] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};

  wire [13:0] obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, outReg, i2, regI, alu_op, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ov(input bit req, input bit we, input bit io, input bit irw,
                                     input bit pcw, input bit [1:0] psrc, input bit rw,
                                     input bit oreg, input bit imm, input bit regi,
                                     input bit [1:0] aop, input bit ill);
    return {req, we, io, irw, pcw, psrc, rw, oreg, imm, regi, aop, ill};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  // One cycle: drive inputs just after the edge, compare mid-cycle, advance to the next edge.
  task automatic step(input string tag, input bit mr, input bit az, input logic [5:0] op,
                      input logic [13:0] exp);
    mem_ready = mr;
    alu_zero  = az;
    opCode    = op;
    #1;
    check({tag, " outs"}, 32'(obs), 32'(exp));
    check({tag, " instret"}, 32'(instret), 32'(retired % (1 << CW)));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input int fw);
    for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, rb(), rop(), ov(1,0,0,0,0,2'b00,0,0,0,0,2'b00,0));
    step("fetch", 1'b1, rb(), rop(), ov(1,0,0,1,1,2'b00,0,0,0,0,2'b00,0));
    step("decode", rb(), rb(), op, '0);
  endtask

  // Instruction-level model: expected control per phase, derived from the opcode's class.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit bz);
    fetch_decode(op, fw);
    case (op)
      6'd0: begin
        step("exec_r", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,0,0,0,0,2'b10,0));
        step("wb_r", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,1,1,0,0,2'b00,0));
        retired++;
      end
      6'd8, 6'd10, 6'd12, 6'd13, 6'd14: begin
        step("exec_i", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,0,0,1,0, (op == 6'd8) ? 2'b00 : 2'b11, 0));
        step("wb_i", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,1,0,0,0,2'b00,0));
        retired++;
      end
      6'd35: begin
        step("exec_lw", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,0,0,1,0,2'b00,0));
        for (int i = 0; i < mw; i++) step("memrd_wait", 1'b0, rb(), rop(), ov(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0));
        step("memrd", 1'b1, rb(), rop(), ov(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0));
        step("wb_mem", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,1,0,0,1,2'b00,0));
        retired++;
      end
      6'd43: begin
        step("exec_sw", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,0,0,1,0,2'b00,0));
        for (int i = 0; i < mw; i++) step("memwr_wait", 1'b0, rb(), rop(), ov(1,1,1,0,0,2'b00,0,0,0,0,2'b00,0));
        step("memwr", 1'b1, rb(), rop(), ov(1,1,1,0,0,2'b00,0,0,0,0,2'b00,0));
        retired++;
      end
      6'd4: begin
        step("branch", rb(), bz, rop(), ov(0,0,0,0,bz,2'b01,0,0,0,0,2'b01,0));
        retired++;
      end
      6'd2: begin
        step("jump", rb(), rb(), rop(), ov(0,0,0,0,1,2'b10,0,0,0,0,2'b00,0));
        retired++;
      end
      default: begin
        for (int i = 0; i < 10; i++) step("trap", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,0,0,0,0,2'b00,1));
      end
    endcase
  endtask

  // Reset edge, check the cleared state, then release through one IDLE cycle.
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = rb();
    alu_zero  = rb();
    opCode    = rop();
    @(posedge clk);
    #1;
    retired = 0;
    check("reset outs", 32'(obs), 32'(0));
    check("reset instret", 32'(instret), 32'(0));
    rst_n = 1'b1;
    step("idle", rb(), rb(), rop(), '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    opCode    = '0;
    do_reset();

    run_instr(6'd0, 0, 0, 1'b0);
    run_instr(6'd35, 0, 3, 1'b0);
    run_instr(6'd4, 0, 0, 1'b1);
    run_instr(6'd4, 0, 0, 1'b0);
    run_instr(6'd43, 0, 0, 1'b0);
    run_instr(6'd2, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr(legal_ops[$urandom_range(9)], $urandom_range(3), $urandom_range(3), rb());

    // Reset lands in the middle of a stalled load.
    fetch_decode(6'd35, 1);
    step("exec_lw", rb(), rb(), rop(), ov(0,0,0,0,0,2'b00,0,0,1,0,2'b00,0));
    step("memrd_wait", 1'b0, rb(), rop(), ov(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0));
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("pre_reset memrd", 32'(obs), 32'(ov(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0)));
    @(posedge clk);
    #1;
    retired = 0;
    check("mid_reset outs", 32'(obs), 32'(0));
    check("mid_reset instret", 32'(instret), 32'(0));
    rst_n = 1'b1;
    step("idle", rb(), rb(), rop(), '0);

    for (int n = 0; n < 10; n++)
      run_instr(legal_ops[$urandom_range(9)], $urandom_range(2), $urandom_range(2), rb());

    run_instr(6'd63, 0, 0, 1'b0);
    do_reset();
    run_instr(6'd0, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
